pe: RTL and testbench
=====================

PE -- requirements
Module: pe

Interface
REQ-001 Parameter DATA_TYPE, default 3'b011, selects operand format: 000 int32, 001 uint32, 010 int16, 011 int8, 100 uint16, 101 uint8; 110/111 SHALL behave as int32.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 mat1  input  32  row operand (A element) entering from the west.
REQ-005 mat2  input  32  column operand (B element) entering from the north.
REQ-006 outp_col  output  32  registered copy of mat2, forwarded south.
REQ-007 outp_row  output  32  registered copy of mat1, forwarded east.
REQ-008 pe_result  output  65  [63:0] accumulator, [64] sticky overflow flag.

Function
REQ-009 Operand extraction SHALL use the low bits only: 8-bit formats use [7:0], 16-bit formats use [15:0], 32-bit formats use [31:0]; unused upper bits SHALL be ignored.
REQ-010 Signed formats SHALL sign-extend operands to 64 bits; unsigned formats SHALL zero-extend them.
REQ-011 The product SHALL be the full-precision a*b, with no truncation, held in 64 bits.
REQ-012 Each non-reset cycle SHALL compute acc <= acc + product, with a 1-cycle latency from input to pe_result.
REQ-013 Accumulation SHALL occur every cycle; there is no valid/enable, and zero operands add 0.
REQ-014 Each non-reset cycle SHALL set outp_row <= mat1 and outp_col <= mat2 as raw 32-bit passthrough, unaffected by DATA_TYPE.
REQ-015 Signed formats SHALL set pe_result[64] when the 64-bit two's-complement add overflows (operand signs equal, result sign differs).
REQ-016 Unsigned formats SHALL set pe_result[64] on carry-out of bit 63.
REQ-017 Once set, pe_result[64] SHALL stay 1 until reset.
REQ-018 On overflow the accumulator SHALL wrap modulo 2^64 and SHALL NOT saturate.
REQ-019 pe_result[63:0] SHALL be driven directly from the accumulator register, with no combinational path from mat1/mat2 to any output.

Reset
REQ-020 With rst=1 at a rising edge, the accumulator, overflow flag, outp_row and outp_col SHALL all become 0.
REQ-021 Reset SHALL take priority over accumulation in the same cycle.
REQ-022 Reset asserted mid-accumulation SHALL discard the partial sum.
REQ-023 Accumulation SHALL resume on the first edge after rst deasserts, starting from 0 plus the current product.
REQ-024 No state SHALL change asynchronously.

Verification
REQ-025 Hold rst=1 for 4 cycles -> pe_result=0, outp_row=0, outp_col=0.
REQ-026 DATA_TYPE=011, after reset apply mat1=2, mat2=3 for 20 cycles -> pe_result rises by 6 per cycle, reaching 120 (0x78); outp_row=0x00000002, outp_col=0x00000003 one cycle after the first apply.
REQ-027 Continue with mat1=0x0A, mat2=0x0B for 20 cycles -> +110 per cycle, reaching 120+2200=2320.
REQ-028 DATA_TYPE=011, mat1=mat2=0xFFFFFFFF -> each cycle adds +1 (int8 -1 * -1), bit 64 stays 0, outp_row=outp_col=0xFFFFFFFF; under DATA_TYPE=101 each cycle adds 65025 instead.
REQ-029 DATA_TYPE=000, mat1=mat2=0x7FFFFFFF -> acc 0x3FFFFFFF00000001 after 1 cycle, 0x7FFFFFFE00000002 after 2; the third add overflows, bit 64=1 and stays 1 on later cycles.
REQ-030 Assert rst for 1 cycle mid-accumulation with mat1=2, mat2=3 -> pe_result=0 and bit 64=0 the cycle after the reset edge, then 6 one cycle later.

Source files
------------

// File: rtl/pe.sv
// ---------------------------------------------------------------------------
// pe : multiply-accumulate processing element for a systolic array.
//
// Each cycle the element multiplies the west operand by the north operand,
// interpreted in the format chosen by DATA_TYPE, and adds the full-precision
// product into a 64-bit wrapping accumulator. A sticky flag records any
// accumulator overflow until reset. Both operands are forwarded unchanged,
// one cycle later, to the east and south neighbours.
//
// Parameters
//   DATA_TYPE  3'b000 int32, 001 uint32, 010 int16, 011 int8,
//              100 uint16, 101 uint8, 110/111 treated as int32
// Ports
//   clk        in   1   rising-edge clock
//   rst        in   1   synchronous active-high reset
//   mat1       in   32  row operand (A element) from the west
//   mat2       in   32  column operand (B element) from the north
//   outp_col   out  32  registered mat2, forwarded south
//   outp_row   out  32  registered mat1, forwarded east
//   pe_result  out  65  [63:0] accumulator, [64] sticky overflow flag
// ---------------------------------------------------------------------------
module pe #(
    parameter logic [2:0] DATA_TYPE = 3'b011
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mat1,
    input  logic [31:0] mat2,
    output logic [31:0] outp_col,
    output logic [31:0] outp_row,
    output logic [64:0] pe_result
);

    localparam bit IS_SIGNED = !((DATA_TYPE == 3'b001) ||
                                 (DATA_TYPE == 3'b100) ||
                                 (DATA_TYPE == 3'b101));

    // Widen the low operand bits to 64 bits. Zero-extended values are
    // non-negative in 64-bit two's complement, so a single signed 64x64
    // multiply (low 64 bits kept) is exact for every supported format.
    function automatic logic signed [63:0] extend(input logic [31:0] v);
        logic signed [63:0] r;
        case (DATA_TYPE)
            3'b001:  r = {32'd0, v};
            3'b010:  r = {{48{v[15]}}, v[15:0]};
            3'b011:  r = {{56{v[7]}}, v[7:0]};
            3'b100:  r = {48'd0, v[15:0]};
            3'b101:  r = {56'd0, v[7:0]};
            default: r = {{32{v[31]}}, v};
        endcase
        return r;
    endfunction

    // Overflow of acc + prod: two's-complement overflow for signed formats,
    // carry out of bit 63 for unsigned formats.
    function automatic logic add_ovf(input logic [63:0] acc,
                                     input logic [63:0] prod,
                                     input logic [64:0] sum);
        logic r;
        if (IS_SIGNED)
            r = (acc[63] == prod[63]) && (sum[63] != acc[63]);
        else
            r = sum[64];
        return r;
    endfunction

    logic signed [63:0] a_p0;
    logic signed [63:0] b_p0;
    logic signed [63:0] product_p0;
    logic        [64:0] sum_p0;
    logic               ovf_p0;

    logic        [63:0] acc_p1;
    logic               ovf_p1;
    logic        [31:0] row_p1;
    logic        [31:0] col_p1;

    // Stage 0: operand extension, multiply and add (combinational)
    always_comb begin
        a_p0       = extend(mat1);
        b_p0       = extend(mat2);
        product_p0 = a_p0 * b_p0;
        sum_p0     = {1'b0, acc_p1} + {1'b0, product_p0};
        ovf_p0     = add_ovf(acc_p1, product_p0, sum_p0);
    end

    // Stage 1: accumulator, sticky flag and forwarded operands
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_p1 <= 64'd0;
            ovf_p1 <= 1'b0;
            row_p1 <= 32'd0;
            col_p1 <= 32'd0;
        end else begin
            acc_p1 <= sum_p0[63:0];
            ovf_p1 <= ovf_p1 | ovf_p0;
            row_p1 <= mat1;
            col_p1 <= mat2;
        end
    end

    assign pe_result = {ovf_p1, acc_p1};
    assign outp_row  = row_p1;
    assign outp_col  = col_p1;

endmodule

// File: tb/tb_pe.sv
// ---------------------------------------------------------------------------
// tb_pe : scoreboard bench for pe. One instance per DATA_TYPE encoding shares
// the same clock, reset and operands. The stimulus process updates a
// behavioural model and pushes the expected post-edge outputs into a queue;
// a monitor pops one entry per clock and compares every instance.
// ---------------------------------------------------------------------------
module tb_pe;

    logic        clk;
    logic        rst;
    logic [31:0] mat1;
    logic [31:0] mat2;
    logic [64:0] res [8];
    logic [31:0] row [8];
    logic [31:0] col [8];

    int checks   = 0;
    int failures = 0;

    for (genvar g = 0; g < 8; g++) begin : g_dut
        pe #(.DATA_TYPE(3'(g))) dut (
            .clk       (clk),
            .rst       (rst),
            .mat1      (mat1),
            .mat2      (mat2),
            .outp_col  (col[g]),
            .outp_row  (row[g]),
            .pe_result (res[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0][64:0] res;
        logic [31:0]      row;
        logic [31:0]      col;
    } exp_t;

    exp_t exp_q[$];

    // Behavioural model state
    logic [63:0] m_acc [8];
    logic        m_ovf [8];
    logic [31:0] m_row;
    logic [31:0] m_col;

    localparam logic signed [65:0] SMAX = 66'sd9223372036854775807;
    localparam logic signed [65:0] SMIN = -66'sd9223372036854775808;

    function automatic bit is_signed_t(input int t);
        return !(t == 1 || t == 4 || t == 5);
    endfunction

    // Numeric value of an operand as a 64-bit pattern
    function automatic logic [63:0] op_val(input int t, input logic [31:0] m);
        logic [63:0] v;
        case (t)
            1: v = 64'(m);
            2: v = 64'($signed(m[15:0]));
            3: v = 64'($signed(m[7:0]));
            4: v = 64'(m[15:0]);
            5: v = 64'(m[7:0]);
            default: v = 64'($signed(m));
        endcase
        return v;
    endfunction

    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Drive one cycle of stimulus and record what the outputs must be after
    // the following rising edge.
    task automatic step(input logic r, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        @(negedge clk);
        rst  = r;
        mat1 = a;
        mat2 = b;
        for (int t = 0; t < 8; t++) begin
            logic [63:0] prod;
            if (r) begin
                m_acc[t] = 64'd0;
                m_ovf[t] = 1'b0;
            end else begin
                if (is_signed_t(t)) begin
                    longint pa, pb;
                    logic signed [65:0] exact;
                    pa    = longint'(op_val(t, a));
                    pb    = longint'(op_val(t, b));
                    prod  = 64'(pa * pb);
                    exact = 66'($signed(m_acc[t])) + 66'($signed(prod));
                    if (exact > SMAX || exact < SMIN) m_ovf[t] = 1'b1;
                end else begin
                    longint unsigned ua, ub;
                    ua   = longint'(op_val(t, a));
                    ub   = longint'(op_val(t, b));
                    prod = 64'(ua * ub);
                    if (m_acc[t] > (64'hFFFF_FFFF_FFFF_FFFF - prod)) m_ovf[t] = 1'b1;
                end
                m_acc[t] = m_acc[t] + prod;
            end
            e.res[t] = {m_ovf[t], m_acc[t]};
        end
        m_row = r ? 32'd0 : a;
        m_col = r ? 32'd0 : b;
        e.row = m_row;
        e.col = m_col;
        exp_q.push_back(e);
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    // Monitor: outputs are valid every cycle, so one entry is consumed per edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                for (int t = 0; t < 8; t++) begin
                    chk($sformatf("pe_result[t%0d]", t), res[t], e.res[t]);
                    chk($sformatf("outp_row[t%0d]", t), 65'(row[t]), 65'(e.row));
                    chk($sformatf("outp_col[t%0d]", t), 65'(col[t]), 65'(e.col));
                end
            end
        end
    end

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h7FFF_FFFF;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'h0000_0000;
            4: return {$urandom_range(0, 65535), 16'h7FFF};
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst  = 1'b1;
        mat1 = 32'd0;
        mat2 = 32'd0;
        for (int t = 0; t < 8; t++) begin
            m_acc[t] = 64'd0;
            m_ovf[t] = 1'b0;
        end
        m_row = 32'd0;
        m_col = 32'd0;

        // Reset held 4 cycles with non-zero operands present
        for (int i = 0; i < 4; i++) step(1'b1, $urandom, $urandom);
        settle();
        chk("reset_result", res[3], 65'd0);
        chk("reset_row", 65'(row[3]), 65'd0);
        chk("reset_col", 65'(col[3]), 65'd0);

        // int8 2*3 for 20 cycles
        step(1'b0, 32'd2, 32'd3);
        settle();
        chk("first_row", 65'(row[3]), 65'h2);
        chk("first_col", 65'(col[3]), 65'h3);
        chk("first_sum", res[3], 65'd6);
        for (int i = 1; i < 20; i++) step(1'b0, 32'd2, 32'd3);
        settle();
        chk("sum_120", res[3], 65'd120);

        // 10*11 for 20 more cycles
        for (int i = 0; i < 20; i++) step(1'b0, 32'h0A, 32'h0B);
        settle();
        chk("sum_2320", res[3], 65'd2320);

        // All-ones operands: int8 -1*-1 and uint8 255*255
        step(1'b1, 32'd0, 32'd0);
        for (int i = 0; i < 5; i++) step(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        settle();
        chk("int8_neg_sum", res[3], 65'd5);
        chk("uint8_sum", res[5], 65'd325125);
        chk("allones_row", 65'(row[3]), 65'hFFFF_FFFF);

        // int32 overflow and stickiness
        step(1'b1, 32'd0, 32'd0);
        step(1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        settle();
        chk("int32_add1", res[0], 65'h0_3FFF_FFFF_0000_0001);
        step(1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        settle();
        chk("int32_add2", res[0], 65'h0_7FFF_FFFE_0000_0002);
        step(1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        settle();
        chk("int32_ovf_set", 65'(res[0][64]), 65'd1);
        step(1'b0, 32'd0, 32'd0);
        step(1'b0, 32'd1, 32'd1);
        settle();
        chk("int32_ovf_sticky", 65'(res[0][64]), 65'd1);

        // Reset mid-accumulation discards the partial sum and the flag
        for (int i = 0; i < 3; i++) step(1'b0, 32'd2, 32'd3);
        step(1'b1, 32'd2, 32'd3);
        settle();
        chk("midreset_zero", res[3], 65'd0);
        chk("midreset_flag", 65'(res[0][64]), 65'd0);
        step(1'b0, 32'd2, 32'd3);
        settle();
        chk("midreset_resume", res[3], 65'd6);

        // Randomized run with occasional resets
        for (int i = 0; i < 600; i++)
            step(($urandom_range(0, 59) == 0), pick(), pick());

        // Drain the scoreboard within a bounded number of cycles
        begin
            int budget;
            budget = 10;
            while (exp_q.size() > 0 && budget > 0) begin
                @(posedge clk);
                #2;
                budget--;
            end
            checks++;
            if (exp_q.size() != 0) begin
                failures++;
                $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
